axi_lite_master_bridge: RTL and testbench
=========================================

AXI_LITE_MASTER_BRIDGE -- requirements
Module: axi_lite_master_bridge

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 16: AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 64: AXI data width; only 64 is supported.
REQ-003 SHALL have one clock and a synchronous, active-low reset, with these ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset.
REQ-004 SHALL have these request-side ports:
- req_valid  in  1  request present.
- req_ready  out  1  request accepted.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- req_wdata  in  32  write word.
- req_wstrb  in  4  write byte enables.
REQ-005 SHALL have these response-side ports:
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  32  read word; 0 for writes.
- rsp_err  out  1  1 when BRESP/RRESP != 2'b00.
REQ-006 SHALL have these AXI write-channel ports:
- M_AXI_AWADDR  out  ADDR_W.
- M_AXI_AWPROT  out  3.
- M_AXI_AWVALID  out  1.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  64.
- M_AXI_WSTRB  out  8.
- M_AXI_WVALID  out  1.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2.
- M_AXI_BVALID  in  1.
- M_AXI_BREADY  out  1.
REQ-007 SHALL have these AXI read-channel ports:
- M_AXI_ARADDR  out  ADDR_W.
- M_AXI_ARPROT  out  3.
- M_AXI_ARVALID  out  1.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  64.
- M_AXI_RRESP  in  2.
- M_AXI_RVALID  in  1.
- M_AXI_RREADY  out  1.

Function
REQ-008 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted on req_valid && req_ready.
REQ-010 SHALL register addr, wdata, wstrb and we on acceptance; no other request is accepted until the response is consumed (one outstanding transaction).
REQ-011 SHALL, on an accepted write, go to WR_ADDR_DATA and assert AWVALID and WVALID together on the next cycle.
REQ-012 SHALL drop AWVALID on the cycle after the AW handshake and WVALID on the cycle after the W handshake, each independently, in either order or in the same cycle.
REQ-013 SHALL go to WR_RESP when both AW and W have handshaken, and assert BREADY only in WR_RESP.
REQ-014 SHALL, on the BVALID && BREADY handshake, capture rsp_err = (BRESP != 0) and rsp_rdata = 0, then go to RSP.
REQ-015 SHALL, on an accepted read, go to RD_ADDR and assert ARVALID until ARREADY, then go to RD_DATA.
REQ-016 SHALL assert RREADY only in RD_DATA.
REQ-017 SHALL, on the RVALID && RREADY handshake, capture rsp_rdata and rsp_err = (RRESP != 0), then go to RSP.
REQ-018 SHALL select the byte lane from addr bit 2:
- Write data: WDATA = addr[2] ? {wdata, 32'h0} : {32'h0, wdata}.
- Write strobes: WSTRB = addr[2] ? {wstrb, 4'h0} : {4'h0, wstrb}.
- Read data: rsp_rdata = addr[2] ? RDATA[63:32] : RDATA[31:0].
REQ-019 SHALL drive AWADDR and ARADDR with the full registered address unmodified, and AWPROT = ARPROT = 3'b000.
REQ-020 SHALL, in RSP, hold rsp_valid high with stable rsp_rdata and rsp_err until rsp_ready, then return to IDLE.
REQ-021 SHALL hold every VALID stable, with stable payload, until its handshake; VALID SHALL NOT depend combinationally on READY.
REQ-022 SHALL have a minimum latency of 4 cycles from request acceptance to rsp_valid when the slave is zero-wait (READY held high, response returned one cycle after the address/data handshake).
REQ-023 SHALL ignore BVALID and RVALID outside WR_RESP and RD_DATA respectively.
REQ-024 SHALL route an illegal state encoding to IDLE with all VALID/READY outputs low.

Reset
REQ-025 SHALL, while M_AXI_ARESETN = 0 at a clock edge, set:
- state = IDLE.
- AWVALID = WVALID = ARVALID = 0, BREADY = RREADY = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- req_ready = 0.
REQ-026 SHALL assert req_ready on the first cycle after M_AXI_ARESETN rises.
REQ-027 SHALL, on reset mid-transaction, abandon the transaction without producing a response; bus quiescence is the system's responsibility.

Verification
REQ-028 Write addr 0x0004, wdata 0xDEADBEEF, wstrb 0xF, zero-wait slave -> WDATA = 0xDEADBEEF_00000000, WSTRB = 0xF0; rsp_err = 0.
REQ-029 Read addr 0x0000, slave RDATA = 0x11112222_33334444 -> rsp_rdata = 0x33334444; read addr 0x0008 with the same RDATA -> rsp_rdata = 0x33334444.
REQ-030 Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID stays high 4 cycles; exactly one response.
REQ-031 Read with RRESP = 2'b10 -> rsp_err = 1; next write with BRESP = 0 -> rsp_err = 0.
REQ-032 rsp_ready held low for 5 cycles with req_valid high -> req_ready = 0 throughout and rsp_rdata stable; exactly one AXI transaction issued.
REQ-033 Reset asserted during WR_RESP -> all outputs at reset values next cycle; new read after reset completes normally.

Source files
------------

// File: rtl/axi_lite_master_bridge.sv
// Bridges a simple 32-bit request/response port onto a 64-bit AXI4-Lite master.
// One transaction is outstanding at a time. The 32-bit word is steered onto the
// upper or lower half of the 64-bit bus by address bit 2.
module axi_lite_master_bridge #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
  // Only 64 is supported; the lane steering assumes two 32-bit halves.
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,

  // Request side
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [31:0]                     req_wdata,
  input  logic [3:0]                      req_wstrb,

  // Response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic                            rsp_err,

  // AXI write channels
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,

  // AXI read channels
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StWrAddrData = 3'd1,
    StWrResp     = 3'd2,
    StRdAddr     = 3'd3,
    StRdData     = 3'd4,
    StRsp        = 3'd5
  } state_e;

  state_e                          state_q, state_d;
  logic                            req_ready_q, req_ready_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]                     wdata_q, wdata_d;
  logic [3:0]                      wstrb_q, wstrb_d;
  logic [31:0]                     rsp_rdata_q, rsp_rdata_d;
  logic                            rsp_err_q, rsp_err_d;

  logic                            aw_hs, w_hs;
  logic                            arvalid, bready, rready, rsp_valid_c;

  assign aw_hs = awvalid_q && M_AXI_AWREADY;
  assign w_hs  = wvalid_q && M_AXI_WREADY;

  // Registered state and captured request/response payload.
  // Direction is held in the state encoding itself (write vs. read branch).
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    arvalid     = 1'b0;
    bready      = 1'b0;
    rready      = 1'b0;
    rsp_valid_c = 1'b0;

    case (state_q)
      StIdle: begin
        // req_ready is registered so it stays low in the cycle reset is released.
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          if (req_we) begin
            state_d   = StWrAddrData;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdAddr;
          end
        end
      end

      StWrAddrData: begin
        // AW and W retire independently; move on once neither is pending.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d = StWrResp;
        end
      end

      StWrResp: begin
        bready = 1'b1;
        if (M_AXI_BVALID) begin
          rsp_err_d   = (M_AXI_BRESP != 2'b00);
          rsp_rdata_d = '0;
          state_d     = StRsp;
        end
      end

      StRdAddr: begin
        arvalid = 1'b1;
        if (M_AXI_ARREADY) state_d = StRdData;
      end

      StRdData: begin
        rready = 1'b1;
        if (M_AXI_RVALID) begin
          rsp_rdata_d = addr_q[2] ? M_AXI_RDATA[63:32] : M_AXI_RDATA[31:0];
          rsp_err_d   = (M_AXI_RRESP != 2'b00);
          state_d     = StRsp;
        end
      end

      StRsp: begin
        rsp_valid_c = 1'b1;
        if (rsp_ready) begin
          state_d     = StIdle;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
      end
    endcase
  end

  // Registered flags are qualified by state so an illegal encoding drives them low.
  assign req_ready     = req_ready_q && (state_q == StIdle);
  assign M_AXI_AWVALID = awvalid_q && (state_q == StWrAddrData);
  assign M_AXI_WVALID  = wvalid_q && (state_q == StWrAddrData);
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_RREADY  = rready;

  assign rsp_valid     = rsp_valid_c;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = addr_q[2] ? {wdata_q, 32'h0} : {32'h0, wdata_q};
  assign M_AXI_WSTRB   = addr_q[2] ? {wstrb_q, 4'h0} : {4'h0, wstrb_q};

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a small configurable AXI-Lite slave.
module tb_axi_lite_master_bridge;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [63:0]   wdata, rdata;
  logic [7:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_master_bridge #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(64)
  ) u_dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave configuration (written by the main sequence only)
  int          aw_dly = 0;
  int          b_dly  = 1;
  int          r_dly  = 1;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;

  // Slave monitor state (written by the slave process only)
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
  int            aw_hi = 0, w_hi = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [2:0]    cap_awprot = '0, cap_arprot = '0;
  logic [63:0]   cap_wdata = '0;
  logic [7:0]    cap_wstrb = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Zero-wait-capable slave: READY follows VALID after aw_dly cycles, responses come
  // b_dly/r_dly cycles after the last address/data handshake.
  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_got, w_got, b_pend, r_pend;
    int   aw_wait, b_wait, r_wait;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_wait = 0; b_wait = 0; r_wait = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (aw_hs) begin
        aw_cnt++; aw_got = 1; cap_awaddr = awaddr; cap_awprot = awprot;
      end
      if (w_hs) begin
        w_cnt++; w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb;
      end
      if (b_hs) b_cnt++;
      if (ar_hs) begin
        ar_cnt++; r_pend = 1; r_wait = r_dly; cap_araddr = araddr; cap_arprot = arprot;
      end
      if (r_hs) r_cnt++;
      if (rsp_valid && rsp_ready) rsp_cnt++;
      if (aw_got && w_got && !b_pend) begin
        b_pend = 1; b_wait = b_dly;
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_wait = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
        if (awvalid) begin
          awready = (aw_wait >= aw_dly);
          aw_wait++;
        end else begin
          awready = 0;
          aw_wait = 0;
        end
        wready  = wvalid;
        arready = arvalid;
        if (b_hs) begin
          bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0;
        end else if (b_pend && !bvalid) begin
          if (b_wait == 0) begin bvalid = 1; bresp = bresp_cfg; end
          else b_wait--;
        end
        if (r_hs) begin
          rvalid = 0; r_pend = 0;
        end else if (r_pend && !rvalid) begin
          if (r_wait == 0) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
          else r_wait--;
        end
      end
    end
  end

  // Present a request and return just after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws);
    int   n;
    logic ok;
    req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1;
    ok = 0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = req_ready;
      n++;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid = 0;
    check_eq("req_accepted", {63'd0, ok}, 64'd1);
  endtask

  // Wait for and consume a response; lat counts the accepting edge as cycle 1.
  task automatic wait_rsp(output logic [31:0] rd, output logic err, output int lat);
    int   n;
    logic got;
    got = 0;
    lat = 1;
    n   = 0;
    rd  = '0;
    err = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
      else lat++;
      n++;
    end
    check_eq("rsp_seen", {63'd0, got}, 64'd1);
    if (got) begin
      rd = rsp_rdata;
      err = rsp_err;
      rsp_ready = 1;
      @(posedge clk);
      #1;
      rsp_ready = 0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic        err;
    int          lat, s_aw, s_w, s_ar, s_b, s_rsp, s_awhi, s_whi, n;
    logic        seen;

    rstn = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {56'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid,
                          req_ready, rsp_err}, 64'd0);
    check_eq("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    @(negedge clk) rstn = 1;
    @(posedge clk);
    #1;
    check_eq("req_ready_after_rst", {63'd0, req_ready}, 64'd1);

    // Upper-lane write, zero-wait slave
    s_aw = aw_cnt; s_b = b_cnt;
    issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    wait_rsp(rd, err, lat);
    check_eq("wr_wdata_hi", cap_wdata, 64'hDEADBEEF_00000000);
    check_eq("wr_wstrb_hi", {56'd0, cap_wstrb}, 64'hF0);
    check_eq("wr_awaddr", {48'd0, cap_awaddr}, 64'h4);
    check_eq("wr_awprot", {61'd0, cap_awprot}, 64'd0);
    check_eq("wr_err", {63'd0, err}, 64'd0);
    check_eq("wr_rdata", {32'd0, rd}, 64'd0);
    check_eq("wr_latency", 64'(lat), 64'd4);
    check_eq("wr_aw_count", 64'(aw_cnt - s_aw), 64'd1);
    check_eq("wr_b_count", 64'(b_cnt - s_b), 64'd1);

    // Reads: lane chosen by addr[2] only
    rdata_cfg = 64'h11112222_33334444;
    issue(1'b0, 16'h0000, '0, '0);
    wait_rsp(rd, err, lat);
    check_eq("rd0_rdata", {32'd0, rd}, 64'h33334444);
    check_eq("rd0_araddr", {48'd0, cap_araddr}, 64'h0);
    check_eq("rd0_arprot", {61'd0, cap_arprot}, 64'd0);
    check_eq("rd_latency", 64'(lat), 64'd4);
    issue(1'b0, 16'h0008, '0, '0);
    wait_rsp(rd, err, lat);
    check_eq("rd8_rdata", {32'd0, rd}, 64'h33334444);
    check_eq("rd8_araddr", {48'd0, cap_araddr}, 64'h8);
    issue(1'b0, 16'h000C, '0, '0);
    wait_rsp(rd, err, lat);
    check_eq("rdC_rdata", {32'd0, rd}, 64'h11112222);
    check_eq("rdC_err", {63'd0, err}, 64'd0);

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_dly = 3;
    s_awhi = aw_hi; s_whi = w_hi; s_rsp = rsp_cnt; s_b = b_cnt;
    issue(1'b1, 16'h0010, 32'h12345678, 4'h3);
    wait_rsp(rd, err, lat);
    aw_dly = 0;
    check_eq("dly_awvalid_cycles", 64'(aw_hi - s_awhi), 64'd4);
    check_eq("dly_wvalid_cycles", 64'(w_hi - s_whi), 64'd1);
    check_eq("dly_rsp_count", 64'(rsp_cnt - s_rsp), 64'd1);
    check_eq("dly_b_count", 64'(b_cnt - s_b), 64'd1);
    check_eq("dly_wdata_lo", cap_wdata, 64'h00000000_12345678);
    check_eq("dly_wstrb_lo", {56'd0, cap_wstrb}, 64'h03);

    // Error responses
    rresp_cfg = 2'b10;
    issue(1'b0, 16'h0000, '0, '0);
    wait_rsp(rd, err, lat);
    check_eq("rresp_err", {63'd0, err}, 64'd1);
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b00;
    issue(1'b1, 16'h0000, 32'hA5A5A5A5, 4'h1);
    wait_rsp(rd, err, lat);
    check_eq("bresp_ok_err", {63'd0, err}, 64'd0);
    bresp_cfg = 2'b11;
    issue(1'b1, 16'h0004, 32'h5A5A5A5A, 4'h2);
    wait_rsp(rd, err, lat);
    check_eq("bresp_dec_err", {63'd0, err}, 64'd1);
    bresp_cfg = 2'b00;

    // Back-pressure on the response with a new request waiting
    rdata_cfg = 64'hAAAA5555_CAFEF00D;
    s_aw = aw_cnt; s_ar = ar_cnt;
    issue(1'b0, 16'h0004, '0, '0);
    req_we = 1; req_addr = 16'h0008; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
    req_valid = 1;
    seen = 0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = rsp_valid;
      n++;
    end
    check_eq("bp_rsp_seen", {63'd0, seen}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
      check_eq("bp_rdata_stable", {32'd0, rsp_rdata}, 64'hAAAA5555);
      @(negedge clk);
    end
    check_eq("bp_ar_count", 64'(ar_cnt - s_ar), 64'd1);
    check_eq("bp_aw_count", 64'(aw_cnt - s_aw), 64'd0);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    issue(1'b1, 16'h0008, 32'h0BADF00D, 4'hF);
    wait_rsp(rd, err, lat);
    check_eq("bp_next_wdata", cap_wdata, 64'h00000000_0BADF00D);
    check_eq("bp_next_wstrb", {56'd0, cap_wstrb}, 64'h0F);

    // Reset while waiting for BVALID; prime rsp_rdata/rsp_err with nonzero values first
    rdata_cfg = 64'h0_13572468;
    rresp_cfg = 2'b10;
    issue(1'b0, 16'h0000, '0, '0);
    wait_rsp(rd, err, lat);
    check_eq("pre_rst_rdata", {32'd0, rd}, 64'h13572468);
    rresp_cfg = 2'b00;
    b_dly = 6;
    s_rsp = rsp_cnt; s_b = b_cnt;
    issue(1'b1, 16'h0004, 32'h55AA55AA, 4'hF);
    seen = 0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = bready;
      n++;
    end
    check_eq("mid_bready_seen", {63'd0, seen}, 64'd1);
    rstn = 0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_ctrl", {56'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid,
                              req_ready, rsp_err}, 64'd0);
    check_eq("mid_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    @(negedge clk) rstn = 1;
    b_dly = 1;
    @(posedge clk);
    #1;
    check_eq("mid_req_ready", {63'd0, req_ready}, 64'd1);
    rdata_cfg = 64'h87654321_00000000;
    issue(1'b0, 16'h0004, '0, '0);
    wait_rsp(rd, err, lat);
    check_eq("post_rst_rdata", {32'd0, rd}, 64'h87654321);
    check_eq("post_rst_err", {63'd0, err}, 64'd0);
    check_eq("post_rst_rsp_count", 64'(rsp_cnt - s_rsp), 64'd1);
    check_eq("post_rst_b_count", 64'(b_cnt - s_b), 64'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
